sw_input_conditioner: RTL and testbench
=======================================

# sw_input_conditioner

Synchronises, debounces and edge-detects the raw board slide switches before they reach the processor's `i_io_sw` input port. It sits directly upstream of the single-cycle core's input I/O. The raw pins are asynchronous and bouncy; the core samples `i_io_sw` combinationally on loads and must only ever see clean, stable levels. The block also provides per-switch rise/fall pulses and a sticky "any switch changed" flag for polling firmware.

## Interface
- `NUM_SW`, default 32: number of switch inputs.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable clocks required before a level is accepted (20 ms at 50 MHz). Legal range is at least 1. Benches override it to 4.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of the per-switch counter. Derived; must not be overridden.
- `i_clk`, in, 1: system clock. Every register is updated on its rising edge.
- `i_reset`, in, 1: synchronous, active-low reset. It is sampled on the `i_clk` rising edge; 0 = reset.
- `i_sw_raw`, in, `NUM_SW`: raw asynchronous switch pins.
- `o_sw`, out, `NUM_SW`: debounced switch levels. Connects to the core's `i_io_sw`.
- `o_sw_rise`, out, `NUM_SW`: one-cycle pulse per bit when that bit of `o_sw` goes 0→1.
- `o_sw_fall`, out, `NUM_SW`: one-cycle pulse per bit when that bit of `o_sw` goes 1→0.
- `o_changed`, out, 1: sticky flag. Set by any rise or fall pulse.
- `i_changed_clr`, in, 1: clears `o_changed`. Level-sensitive, single-cycle use expected.

## Operation
- **Synchroniser.** A two-flop chain per bit: `sync1 <= i_sw_raw`, `sync2 <= sync1`. Only `sync2` is used downstream. There are no combinational paths from `i_sw_raw` to any output.
- **Per-bit debounce counter** `cnt[i]` (`CNT_W` bits). Evaluated on each edge:
  - If `sync2[i] == o_sw[i]`: `cnt[i] <= 0`.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `o_sw[i] <= sync2[i]`, `cnt[i] <= 0`, and the matching rise or fall pulse is asserted.
  - Else: `cnt[i] <= cnt[i]+1`.
- **Glitch rejection.** Any return of `sync2[i]` to the current `o_sw[i]` before terminal count restarts the count from 0. There is no partial credit.
- **Counter width.** The counter never exceeds `DEBOUNCE_CYCLES-1`, so there is no wrap-around.
- **Independence.** Bits are fully independent. Any number of bits may flip on the same edge.
- **Pulses.** `o_sw_rise[i]` and `o_sw_fall[i]` are registered. They are high for exactly the one cycle following the edge on which `o_sw[i]` changes, and never both high for the same bit.
- **Sticky flag.** `o_changed <= (o_changed & ~i_changed_clr) | (|next_rise) | (|next_fall)`. When a set and `i_changed_clr` occur on the same edge, set wins.
- **Reset values.** While `i_reset==0` at an edge, all of the following are cleared to 0: `sync1`, `sync2`, `o_sw`, every `cnt`, `o_sw_rise`, `o_sw_fall`, `o_changed`.
- **Reset mid-count.** Reset discards partial counts.
- **Switch held high through reset.** Such a switch is re-qualified after release. It produces a normal rise pulse after the full latency.

## Timing
- **Latency.** Raw level first sampled into `sync1` at edge k (held stable from then on):
  - `sync2` updates at k+1.
  - The first counting edge is k+2.
  - `o_sw` and the pulse update at edge k+1+`DEBOUNCE_CYCLES`.
  - With `DEBOUNCE_CYCLES=4`, `o_sw` changes at k+5.
- **Minimum accepted stable width.** `DEBOUNCE_CYCLES` clocks measured at `sync2`. Shorter excursions are never seen at `o_sw`.
- **`DEBOUNCE_CYCLES=1`.** `o_sw` follows `sync2` with one register stage: latency k+2.
- **Clear timing.** `o_changed` reads 0 in the cycle after an edge that sampled `i_changed_clr=1`, provided no pulse was generated on that edge.
- **Throughput.** One accepted transition per bit per `DEBOUNCE_CYCLES` clocks maximum.

## Test plan
All scenarios use `NUM_SW=8` and `DEBOUNCE_CYCLES=4`.
- **Reset.** Hold `i_reset=0` for 3 cycles with `i_sw_raw=8'hFF`. During reset: `o_sw=0`, rise=0, fall=0, `o_changed=0`. After release: `o_sw=8'hFF` exactly 5 edges after the first sample, `o_sw_rise=8'hFF` for one cycle, `o_changed=1`.
- **Clean toggle.** `i_sw_raw` goes 8'h00→8'h05 at edge k. `o_sw=8'h05` after edge k+5. `o_sw_rise=8'h05` for one cycle only. `o_sw_fall=0`.
- **Bounce rejection.** Bit 3 toggles high for 3 cycles, low for 1, high for 2, then low. `o_sw[3]` stays 0, with no pulses. A subsequent 4-cycle-stable high is accepted at the +5 latency.
- **Fall plus sticky clear.** From `o_sw=8'h05`, drive raw 8'h04. `o_sw_fall=8'h01` for one cycle. Assert `i_changed_clr` for one cycle later: `o_changed` goes 0.
- **Clear collides with set.** Assert `i_changed_clr` on the same edge a rise pulse is generated. `o_changed` remains 1.
- **Reset mid-count.** Raw bit 7 rises. Pull `i_reset` low for 1 cycle two edges later. `o_sw[7]=0` with no pulse until 5 edges after reset release.

Source files
------------

// File: rtl/sw_input_conditioner.sv
// Two-flop synchroniser, per-bit debounce counter and edge detector for raw slide switches.
// o_sw only changes after DEBOUNCE_CYCLES consecutive disagreeing samples at the second sync flop.
module sw_input_conditioner #(
   parameter int NUM_SW          = 32,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [NUM_SW-1:0] i_sw_raw,
   input  logic              i_changed_clr,
   output logic [NUM_SW-1:0] o_sw,
   output logic [NUM_SW-1:0] o_sw_rise,
   output logic [NUM_SW-1:0] o_sw_fall,
   output logic              o_changed
);

   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_SW-1:0] sync1_reg;
   logic [NUM_SW-1:0] sync2_reg;
   logic [NUM_SW-1:0] sw_reg;
   logic [NUM_SW-1:0] sw_next;
   logic [NUM_SW-1:0] rise_reg;
   logic [NUM_SW-1:0] rise_next;
   logic [NUM_SW-1:0] fall_reg;
   logic [NUM_SW-1:0] fall_next;
   logic              changed_reg;
   logic              changed_next;

   generate
      for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_bit
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;
         logic             sw_bit_next;
         logic             rise_bit_next;
         logic             fall_bit_next;

         // Any sample agreeing with the accepted level throws away the partial count.
         always_comb begin
            cnt_next      = cnt_reg;
            sw_bit_next   = sw_reg[gi];
            rise_bit_next = 1'b0;
            fall_bit_next = 1'b0;
            if (sync2_reg[gi] == sw_reg[gi]) begin
               cnt_next = '0;
            end else if (cnt_reg == CNT_TERM) begin
               cnt_next      = '0;
               sw_bit_next   = sync2_reg[gi];
               rise_bit_next = sync2_reg[gi];
               fall_bit_next = ~sync2_reg[gi];
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end

         always_ff @(posedge i_clk) begin
            if (!i_reset) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_next;
            end
         end

         assign sw_next[gi]   = sw_bit_next;
         assign rise_next[gi] = rise_bit_next;
         assign fall_next[gi] = fall_bit_next;
      end
   endgenerate

   // A new pulse outranks a simultaneous clear so no change is ever lost.
   assign changed_next = (changed_reg & ~i_changed_clr) | (|rise_next) | (|fall_next);

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         sync1_reg   <= '0;
         sync2_reg   <= '0;
         sw_reg      <= '0;
         rise_reg    <= '0;
         fall_reg    <= '0;
         changed_reg <= 1'b0;
      end else begin
         sync1_reg   <= i_sw_raw;
         sync2_reg   <= sync1_reg;
         sw_reg      <= sw_next;
         rise_reg    <= rise_next;
         fall_reg    <= fall_next;
         changed_reg <= changed_next;
      end
   end

   assign o_sw      = sw_reg;
   assign o_sw_rise = rise_reg;
   assign o_sw_fall = fall_reg;
   assign o_changed = changed_reg;

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Scoreboard bench for sw_input_conditioner: directed scenarios plus random bouncing switches,
// checked against a window-based reference model (a level is accepted once the last N sync samples all disagree).
module tb_sw_input_conditioner;

   localparam int NSW = 8;
   localparam int DB  = 4;
   localparam int HN  = 8192;

   logic           i_clk;
   logic           i_reset;
   logic [NSW-1:0] i_sw_raw;
   logic           i_changed_clr;
   logic [NSW-1:0] o_sw;
   logic [NSW-1:0] o_sw_rise;
   logic [NSW-1:0] o_sw_fall;
   logic           o_changed;

   sw_input_conditioner #(
      .NUM_SW          (NSW),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_sw_raw      (i_sw_raw),
      .i_changed_clr (i_changed_clr),
      .o_sw          (o_sw),
      .o_sw_rise     (o_sw_rise),
      .o_sw_fall     (o_sw_fall),
      .o_changed     (o_changed)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct packed {
      logic [NSW-1:0] sw;
      logic [NSW-1:0] rise;
      logic [NSW-1:0] fall;
      logic           chg;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: sampled history at the second sync stage, indexed by edge number.
   logic [NSW-1:0] hist [HN];
   logic [NSW-1:0] m_s1 = '0;
   logic [NSW-1:0] m_s2 = '0;
   logic [NSW-1:0] m_sw = '0;
   logic           m_chg = 1'b0;
   int             last_ev [NSW];
   int             t_edge = 0;
   logic [NSW-1:0] raw_cur = '0;

   initial begin
      for (int b = 0; b < NSW; b++) last_ev[b] = -100;
   end

   task automatic model_step(input logic [NSW-1:0] raw, input logic rst_n, input logic clr,
                             output exp_t e);
      logic [NSW-1:0] rise;
      logic [NSW-1:0] fall;
      logic           ok;
      rise = '0;
      fall = '0;
      t_edge++;
      if (!rst_n) begin
         m_s1  = '0;
         m_s2  = '0;
         m_sw  = '0;
         m_chg = 1'b0;
         for (int b = 0; b < NSW; b++) last_ev[b] = t_edge;
      end else begin
         hist[t_edge % HN] = m_s2;
         m_s2 = m_s1;
         m_s1 = raw;
         for (int b = 0; b < NSW; b++) begin
            ok = (t_edge - last_ev[b]) >= DB;
            for (int j = 0; j < DB; j++) begin
               if (hist[(t_edge - j) % HN][b] == m_sw[b]) ok = 1'b0;
            end
            if (ok) begin
               if (m_sw[b]) fall[b] = 1'b1;
               else         rise[b] = 1'b1;
               m_sw[b]    = ~m_sw[b];
               last_ev[b] = t_edge;
            end
         end
         m_chg = (m_chg & ~clr) | (|rise) | (|fall);
      end
      e.sw   = m_sw;
      e.rise = rise;
      e.fall = fall;
      e.chg  = m_chg;
   endtask

   // Present inputs for the next edge, record its expected outcome, then let the edge happen.
   task automatic drive(input logic [NSW-1:0] raw, input logic rst_n, input logic clr);
      exp_t e;
      i_sw_raw      = raw;
      i_reset       = rst_n;
      i_changed_clr = clr;
      model_step(raw, rst_n, clr, e);
      sb_q.push_back(e);
      @(posedge i_clk);
      #1;
   endtask

   task automatic hold(input logic [NSW-1:0] raw, input int n);
      for (int i = 0; i < n; i++) drive(raw, 1'b1, 1'b0);
   endtask

   task automatic chk(input string name, input logic [NSW-1:0] got, input logic [NSW-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s edge=%0d got=%h expected=%h", name, checks / 4, got, want);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("o_sw", o_sw, e.sw);
            chk("o_sw_rise", o_sw_rise, e.rise);
            chk("o_sw_fall", o_sw_fall, e.fall);
            chk("o_changed", {7'd0, o_changed}, {7'd0, e.chg});
            $display("edge raw=%h rst=%b clr=%b sw=%h rise=%h fall=%h chg=%b", i_sw_raw, i_reset,
                     i_changed_clr, o_sw, o_sw_rise, o_sw_fall, o_changed);
         end
      end
   end

   initial begin : stimulus
      // Reset with all switches high, then re-qualification after release.
      for (int i = 0; i < 3; i++) drive(8'hFF, 1'b0, 1'b0);
      hold(8'hFF, 10);
      // Everything falls, then clean rise on bits 0 and 2.
      hold(8'h00, 10);
      hold(8'h05, 10);
      // Bounce on bit 3: high 3, low 1, high 2, then low; later a clean high.
      hold(8'h0D, 3);
      hold(8'h05, 1);
      hold(8'h0D, 2);
      hold(8'h05, 8);
      hold(8'h0D, 8);
      hold(8'h05, 8);
      // Fall on bit 0, then clear the sticky flag.
      hold(8'h04, 10);
      drive(8'h04, 1'b1, 1'b1);
      hold(8'h04, 3);
      // Clear lands on the same edge as a rise pulse.
      for (int i = 0; i < 5; i++) drive(8'h05, 1'b1, 1'b0);
      drive(8'h05, 1'b1, 1'b1);
      hold(8'h05, 4);
      // Reset in the middle of a bit-7 count.
      drive(8'h85, 1'b1, 1'b0);
      drive(8'h85, 1'b1, 1'b0);
      drive(8'h85, 1'b0, 1'b0);
      hold(8'h85, 10);
      // Random bouncing switches with occasional clears and resets.
      raw_cur = 8'h85;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 15) == 0) begin
            raw_cur = 8'($urandom);
         end else begin
            for (int b = 0; b < NSW; b++) begin
               if ($urandom_range(0, 7) == 0) raw_cur[b] = ~raw_cur[b];
            end
         end
         if ((c % 60) >= 50) begin
            hold(raw_cur, 1);
         end else begin
            drive(raw_cur, ($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0));
         end
      end
      hold(raw_cur, 2);
      @(negedge i_clk);
      @(negedge i_clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
